// File: rtl/hazard_interlock_pkg.sv
// hazard_pkg: shared types and helpers for the pipeline hazard interlock.
//   sb_entry_t   - one scoreboard entry {valid, dest, is_load}
//   XZR          - register 31, the zero register, never a hazard source
//   ilk_state_t  - interlock FSM states {RUN, STALL1, STALL2}
//   SB_EMPTY     - the invalid (bubble) entry; its dest reads back as XZR
package hazard_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } sb_entry_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL1 = 2'd1,
    STALL2 = 2'd2
  } ilk_state_t;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, dest: XZR, is_load: 1'b0};

  // Writes to XZR are discarded by the register file, so they never
  // become a tracked producer.
  function automatic sb_entry_t make_entry(input logic [4:0] dest,
                                           input logic       reg_write,
                                           input logic       is_load);
    sb_entry_t e;
    e.valid   = reg_write && (dest != XZR);
    e.dest    = dest;
    e.is_load = is_load;
    return e;
  endfunction

  // Destination number seen by the forwarding controller.
  function automatic logic [4:0] entry_dest(input sb_entry_t e);
    return e.valid ? e.dest : XZR;
  endfunction

  // True when a source that is actually read matches a live producer.
  function automatic logic src_hit(input logic       used,
                                   input logic [4:0] src,
                                   input sb_entry_t  e);
    return used && (src != XZR) && e.valid && (e.dest == src);
  endfunction

endpackage

// File: rtl/hazard_interlock_if.sv
// hazard_interlock_if: decode-side request bundle and interlock responses.
//   master modport - pipeline side: drives decode/EX/memory status,
//                    receives enables, bubble/flush/freeze, stage dests
//                    and performance counters.
//   slave modport  - the interlock itself (mirror of master).
interface hazard_interlock_if;

  logic [4:0]  ReadRegister1_ID;
  logic [4:0]  ReadRegister2_ID;
  logic        use_rn_ID;
  logic        use_rm_ID;
  logic        cbz_ID;
  logic [4:0]  WriteRegister_ID;
  logic        reg_write_ID;
  logic        mem_read_ID;
  logic        branch_taken_EX;
  logic        mem_busy;

  logic        pc_en;
  logic        ifid_en;
  logic        idex_bubble;
  logic        ifid_flush;
  logic        freeze;
  logic [4:0]  WriteRegister_EX;
  logic [4:0]  WriteRegister_MEM;
  logic [4:0]  WriteRegister_WB;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  modport master (
    output ReadRegister1_ID, ReadRegister2_ID, use_rn_ID, use_rm_ID, cbz_ID,
           WriteRegister_ID, reg_write_ID, mem_read_ID, branch_taken_EX,
           mem_busy,
    input  pc_en, ifid_en, idex_bubble, ifid_flush, freeze,
           WriteRegister_EX, WriteRegister_MEM, WriteRegister_WB,
           stall_cycles, flush_count
  );

  modport slave (
    input  ReadRegister1_ID, ReadRegister2_ID, use_rn_ID, use_rm_ID, cbz_ID,
           WriteRegister_ID, reg_write_ID, mem_read_ID, branch_taken_EX,
           mem_busy,
    output pc_en, ifid_en, idex_bubble, ifid_flush, freeze,
           WriteRegister_EX, WriteRegister_MEM, WriteRegister_WB,
           stall_cycles, flush_count
  );

endinterface

// File: rtl/hazard_interlock_sb_stage.sv
// sb_stage: one scoreboard entry register.
//   clk, reset_n - clock and synchronous active-low reset (clears to empty)
//   hold         - keep the current entry (pipeline frozen)
//   bubble       - load an empty entry instead of d
//   d, q         - incoming and stored entry
module sb_stage
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      hold,
  input  logic      bubble,
  input  sb_entry_t d,
  output sb_entry_t q
);

  // Hold has priority over bubble so a frozen pipeline never loses a producer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= SB_EMPTY;
    end else if (!hold) begin
      q <= bubble ? SB_EMPTY : d;
    end
  end

endmodule

// File: rtl/hazard_interlock.sv
// hazard_interlock: stall/flush/freeze interlock and destination scoreboard
// for the 5-stage pipeline.
//   clk, reset_n - clock, synchronous active-low reset
//   bus (slave)  - decode sources/dest, branch_taken_EX, mem_busy in;
//                  pc_en, ifid_en, idex_bubble, ifid_flush, freeze,
//                  WriteRegister_EX/MEM/WB, stall_cycles, flush_count out
// Optional build macro HAZARD_PERF_CNT_EN adds the stall/flush counters;
// without it both counter outputs are tied to zero.
module hazard_interlock
  import hazard_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  hazard_interlock_if.slave bus
);

  sb_entry_t  id_entry, ex_q, mem_q, wb_q;
  ilk_state_t state_q, state_d, cycle_state;

  logic load_use, cbz_load_ex, cbz_load_mem;
  logic stall_now, flush_now, freeze_now;
  logic pc_en, ifid_en, idex_bubble, ifid_flush;
  logic unused_wb_load;

  // The WB entry only feeds the forwarding destination; its load flag is
  // carried for uniformity of the stage register.
  assign unused_wb_load = wb_q.is_load;

  assign id_entry = make_entry(bus.WriteRegister_ID, bus.reg_write_ID,
                               bus.mem_read_ID);

  // CBZ reads its operand in decode, so an ALU producer in EX is covered by
  // forwarding; only load producers in EX or MEM force a wait.
  always_comb begin
    load_use     = ex_q.is_load &&
                   (src_hit(bus.use_rn_ID, bus.ReadRegister1_ID, ex_q) ||
                    src_hit(bus.use_rm_ID, bus.ReadRegister2_ID, ex_q));
    cbz_load_ex  = ex_q.is_load &&
                   src_hit(bus.cbz_ID, bus.ReadRegister2_ID, ex_q);
    cbz_load_mem = mem_q.is_load &&
                   src_hit(bus.cbz_ID, bus.ReadRegister2_ID, mem_q);
  end

  // cycle_state is the state the interlock occupies in this cycle: a hazard
  // seen in RUN takes effect immediately so the dependent instruction is
  // held in decode on the very cycle it is detected.  STALL2 always yields
  // to STALL1 for the second cycle of a CBZ-on-load wait.
  always_comb begin
    cycle_state = RUN;
    case (state_q)
      STALL2: cycle_state = STALL1;
      default: begin
        if (cbz_load_ex) begin
          cycle_state = STALL2;
        end else if (load_use || cbz_load_mem) begin
          cycle_state = STALL1;
        end
      end
    endcase
  end

  // Output decode and next state, in priority order reset > freeze >
  // flush > stall.  A taken branch discards the stalled instruction, so the
  // pending stall is dropped rather than deferred.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    freeze_now  = 1'b0;
    stall_now   = 1'b0;
    flush_now   = 1'b0;
    state_d     = cycle_state;
    if (!reset_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      state_d     = RUN;
    end else if (bus.mem_busy) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      freeze_now = 1'b1;
      state_d    = state_q;
    end else if (bus.branch_taken_EX) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_now   = 1'b1;
      state_d     = RUN;
    end else if (cycle_state != RUN) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      stall_now   = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Scoreboard: EX takes the decode entry or a bubble, MEM and WB shift.
  sb_stage u_sb_ex (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (freeze_now),
    .bubble  (stall_now || flush_now),
    .d       (id_entry),
    .q       (ex_q)
  );

  sb_stage u_sb_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (freeze_now),
    .bubble  (1'b0),
    .d       (ex_q),
    .q       (mem_q)
  );

  sb_stage u_sb_wb (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (freeze_now),
    .bubble  (1'b0),
    .d       (mem_q),
    .q       (wb_q)
  );

  assign bus.pc_en             = pc_en;
  assign bus.ifid_en           = ifid_en;
  assign bus.idex_bubble       = idex_bubble;
  assign bus.ifid_flush        = ifid_flush;
  assign bus.freeze            = freeze_now;
  assign bus.WriteRegister_EX  = entry_dest(ex_q);
  assign bus.WriteRegister_MEM = entry_dest(mem_q);
  assign bus.WriteRegister_WB  = entry_dest(wb_q);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;

  // Counters wrap naturally; frozen cycles are not counted as stalls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall_now) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush_now) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_count  = flush_cnt;
`else
  assign bus.stall_cycles = 32'd0;
  assign bus.flush_count  = 32'd0;
`endif

endmodule
